// File: rtl/sample_buffer_pkg.sv
// Shared defaults and width helper for the sample buffer.
package sample_buffer_pkg;

  localparam int DEF_DATA_W   = 32;
  localparam int DEF_DEPTH    = 8;
  localparam int DEF_AFULL_TH = 6;
  localparam int DEF_DROP_W   = 16;

  // Width of a wrap-bit pointer and of the 0..depth level value.
  function automatic int lvl_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/sample_buffer_if.sv
// Bundles the sampler input, consumer stream and status lines of the sample buffer.
interface sample_buffer_if
  import sample_buffer_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = DEF_DEPTH,
  parameter int DROP_W = DEF_DROP_W
);

  logic                      valid_i;
  logic [DATA_W-1:0]         data_i;
  logic                      valid_o;
  logic                      ready_i;
  logic [DATA_W-1:0]         data_o;
  logic [lvl_w(DEPTH)-1:0]   level_o;
  logic                      afull_o;
  logic                      overflow_o;
  logic [DROP_W-1:0]         drop_cnt_o;
  logic                      clr_i;

  // Buffer side.
  modport slave (
    input  valid_i, data_i, ready_i, clr_i,
    output valid_o, data_o, level_o, afull_o, overflow_o, drop_cnt_o
  );

  // Sampler / consumer / supervisor side.
  modport master (
    output valid_i, data_i, ready_i, clr_i,
    input  valid_o, data_o, level_o, afull_o, overflow_o, drop_cnt_o
  );

endinterface

// File: rtl/sample_fifo_ram.sv
// Sample storage: one synchronous write port, one asynchronous (show-ahead) read port, no reset.
module sample_fifo_ram #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 8
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [DATA_W-1:0]        wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [DATA_W-1:0]        rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Write the accepted sample into its slot.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/sample_buffer.sv
// Absorbs unstallable sampler pulses into a show-ahead FIFO and re-presents them
// on a valid/ready stream, with level, almost-full, sticky overflow and drop count.
module sample_buffer
  import sample_buffer_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int DEPTH    = DEF_DEPTH,
  parameter int AFULL_TH = DEF_AFULL_TH,
  parameter int DROP_W   = DEF_DROP_W
) (
  input  logic             slow_clk,
  input  logic             rst,
  sample_buffer_if.slave   bus
);

  localparam int LW = lvl_w(DEPTH);
  localparam int AW = $clog2(DEPTH);

  logic [LW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [LW-1:0]     rd_ptr_q, rd_ptr_d;
  logic              overflow_q, overflow_d;
  logic [DROP_W-1:0] drop_cnt_q, drop_cnt_d;

  logic          empty, full, pop, push, drop;
  logic [LW-1:0] level;

  // Pointer compare: the MSB is a wrap bit, so equal pointers mean empty and
  // equal indices with differing wrap bits mean full.
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
  assign level = wr_ptr_q - rd_ptr_q;

  assign pop  = !empty && bus.ready_i;
  // A pop in the same cycle frees a slot, so a full FIFO still takes the sample.
  assign push = bus.valid_i && (!full || pop);
  assign drop = bus.valid_i && full && !pop;

  // Next-state for pointers, sticky flag and saturating drop counter.
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    overflow_d = overflow_q;
    drop_cnt_d = drop_cnt_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + LW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + LW'(1);
    end
    if (bus.clr_i) begin
      // A drop coinciding with the clear is counted as the first new event.
      overflow_d = drop;
      drop_cnt_d = drop ? DROP_W'(1) : '0;
    end else if (drop) begin
      overflow_d = 1'b1;
      if (drop_cnt_q != {DROP_W{1'b1}}) begin
        drop_cnt_d = drop_cnt_q + DROP_W'(1);
      end
    end
  end

  // State registers, cleared asynchronously.
  always_ff @(posedge slow_clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      overflow_q <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      overflow_q <= overflow_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  sample_fifo_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_ram (
    .clk   (slow_clk),
    .we    (push),
    .waddr (wr_ptr_q[AW-1:0]),
    .wdata (bus.data_i),
    .raddr (rd_ptr_q[AW-1:0]),
    .rdata (bus.data_o)
  );

  // All status outputs come from registered state only.
  assign bus.valid_o    = !empty;
  assign bus.level_o    = level;
  assign bus.afull_o    = (level >= LW'(AFULL_TH));
  assign bus.overflow_o = overflow_q;
  assign bus.drop_cnt_o = drop_cnt_q;

endmodule

// File: tb/tb_sample_buffer.sv
// Directed plus randomized bench for sample_buffer against a queue-based reference model.
module tb_sample_buffer;

  localparam int DATA_W   = 32;
  localparam int DEPTH    = 8;
  localparam int AFULL_TH = 6;
  localparam int DROP_W   = 4;
  localparam int DROP_MAX = (1 << DROP_W) - 1;

  logic clk;
  logic rst_n;

  sample_buffer_if #(.DATA_W(DATA_W), .DEPTH(DEPTH), .DROP_W(DROP_W)) bus ();

  sample_buffer #(
    .DATA_W   (DATA_W),
    .DEPTH    (DEPTH),
    .AFULL_TH (AFULL_TH),
    .DROP_W   (DROP_W)
  ) dut (
    .slow_clk (clk),
    .rst      (rst_n),
    .bus      (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: a queue of stored samples plus flag and counter.
  int unsigned q[$];
  bit          m_ovf;
  int          m_cnt;

  int vectors;
  int miscompares;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("valid_o", 64'(bus.valid_o), 64'(q.size() > 0));
    chk("level_o", 64'(bus.level_o), 64'(q.size()));
    chk("afull_o", 64'(bus.afull_o), 64'(q.size() >= AFULL_TH));
    chk("overflow_o", 64'(bus.overflow_o), 64'(m_ovf));
    chk("drop_cnt_o", 64'(bus.drop_cnt_o), 64'(m_cnt));
    if (q.size() > 0) begin
      chk("data_o", 64'(bus.data_o), 64'(q[0]));
    end
  endtask

  // One clock: drive inputs, let the edge happen, advance the model, check at negedge.
  task automatic step(input bit v, input int unsigned d, input bit r, input bit c);
    bit pop, drop;
    bus.valid_i = v;
    bus.data_i  = d;
    bus.ready_i = r;
    bus.clr_i   = c;
    @(posedge clk);
    pop  = (q.size() > 0) && r;
    drop = v && (q.size() == DEPTH) && !pop;
    if (pop) void'(q.pop_front());
    if (v && !drop) q.push_back(d);
    if (c) begin
      m_ovf = drop;
      m_cnt = drop ? 1 : 0;
    end else if (drop) begin
      m_ovf = 1'b1;
      if (m_cnt < DROP_MAX) m_cnt++;
    end
    @(negedge clk);
    bus.valid_i = 1'b0;
    check_all();
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    m_ovf       = 1'b0;
    m_cnt       = 0;
    bus.valid_i = 1'b0;
    bus.data_i  = '0;
    bus.ready_i = 1'b0;
    bus.clr_i   = 1'b0;
    rst_n       = 1'b0;

    // Reset state.
    repeat (2) @(negedge clk);
    check_all();
    chk("rst_valid", 64'(bus.valid_o), 64'(0));
    rst_n = 1'b1;
    step(0, 0, 0, 0);

    // Three pulses, consumer not ready.
    step(1, 32'hA1, 0, 0);
    step(1, 32'hA2, 0, 0);
    step(1, 32'hA3, 0, 0);
    chk("tp1_level", 64'(bus.level_o), 64'(3));
    chk("tp1_data", 64'(bus.data_o), 64'(32'hA1));
    chk("tp1_valid", 64'(bus.valid_o), 64'(1));

    // Drain them in order.
    for (int i = 0; i < 3; i++) begin
      chk("tp2_data", 64'(bus.data_o), 64'(32'hA1 + i));
      step(0, 0, 1, 0);
    end
    chk("tp2_level", 64'(bus.level_o), 64'(0));
    chk("tp2_valid", 64'(bus.valid_o), 64'(0));

    // Ten pulses into a depth-8 FIFO: afull at 6, two drops.
    for (int i = 1; i <= 10; i++) begin
      step(1, i, 0, 0);
      if (i == 5) chk("afull_at5", 64'(bus.afull_o), 64'(0));
      if (i == 6) chk("afull_at6", 64'(bus.afull_o), 64'(1));
    end
    chk("tp3_level", 64'(bus.level_o), 64'(8));
    chk("tp3_ovf", 64'(bus.overflow_o), 64'(1));
    chk("tp3_drops", 64'(bus.drop_cnt_o), 64'(2));
    for (int i = 1; i <= 8; i++) begin
      chk("tp3_drain", 64'(bus.data_o), 64'(i));
      step(0, 0, 1, 0);
    end

    // Refill, then push and pop together while full.
    for (int i = 0; i < 8; i++) step(1, 32'h200 + i, 0, 0);
    for (int i = 0; i < 4; i++) begin
      step(1, 32'h300 + i, 1, 0);
      chk("tp4_level", 64'(bus.level_o), 64'(8));
    end
    chk("tp4_drops", 64'(bus.drop_cnt_o), 64'(2));
    chk("tp4_head", 64'(bus.data_o), 64'(32'h204));

    // Clear, then saturate the drop counter.
    step(0, 0, 0, 1);
    chk("clr_cnt", 64'(bus.drop_cnt_o), 64'(0));
    for (int i = 0; i < 20; i++) step(1, 32'hDEAD0000 + i, 0, 0);
    chk("sat_cnt", 64'(bus.drop_cnt_o), 64'(15));
    step(1, 32'hBEEF, 0, 1);
    chk("clr_drop_cnt", 64'(bus.drop_cnt_o), 64'(1));
    chk("clr_drop_ovf", 64'(bus.overflow_o), 64'(1));
    chk("clr_level", 64'(bus.level_o), 64'(8));

    // Mid-stream asynchronous reset at level 5.
    for (int i = 0; i < 3; i++) step(0, 0, 1, 0);
    chk("pre_rst_level", 64'(bus.level_o), 64'(5));
    #2 rst_n = 1'b0;
    #1;
    q.delete();
    m_ovf = 1'b0;
    m_cnt = 0;
    chk("async_valid", 64'(bus.valid_o), 64'(0));
    chk("async_level", 64'(bus.level_o), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;
    step(1, 32'h55, 0, 0);
    chk("post_rst_data", 64'(bus.data_o), 64'(32'h55));

    // Randomized traffic.
    for (int i = 0; i < 500; i++) begin
      step(($urandom_range(0, 9) < 6), $urandom, $urandom_range(0, 1) == 1,
           ($urandom_range(0, 19) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
